// File: rtl/onchip_mem_test_master.sv
// Avalon-MM self-test master: writes a seed+i*STEP pattern over a word window, reads it back and counts mismatches.
// Define MEM_TEST_ERRLOG_EN to add first-mismatch address/data capture ports.
module onchip_mem_test_master #(
  parameter int          DEPTH        = 51200,
  parameter int          ADDR_W       = 16,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] STEP         = 32'h9E3779B9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [31:0]       i_seed,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_cfg_err,
  output logic [15:0]       o_err_count,
`ifdef MEM_TEST_ERRLOG_EN
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [31:0]       o_first_err_data,
`endif
  output logic [ADDR_W-1:0] o_m_address,
  output logic [3:0]        o_m_byteenable,
  output logic              o_m_chipselect,
  output logic              o_m_write,
  output logic [31:0]       o_m_writedata,
  input  logic [31:0]       i_m_readdata
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  function automatic logic [ADDR_W-1:0] f_wrap(input logic [ADDR_W:0] s);
    return ADDR_W'((s >= LP_DEPTH) ? (s - LP_DEPTH) : s);
  endfunction

  state_t            r_state;
  logic [31:0]       r_seed;
  logic [31:0]       r_pat;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_rem;
  logic [7:0]        r_drain;
  // Expected-data delay line; entry 0 belongs to the read on the bus this cycle.
  logic              r_pv [0:READ_LATENCY];
  logic [31:0]       r_pd [0:READ_LATENCY];
`ifdef MEM_TEST_ERRLOG_EN
  logic [ADDR_W-1:0] r_pa [0:READ_LATENCY];
`endif

  logic              w_bad_window;
  logic [ADDR_W-1:0] w_next_addr;
  logic [31:0]       w_pat_next;
  logic              w_mismatch;
  logic [15:0]       w_err_next;

  assign w_bad_window = ({1'b0, i_base} >= LP_DEPTH) || ({1'b0, i_count} > LP_DEPTH);
  assign w_next_addr  = f_wrap({1'b0, o_m_address} + (ADDR_W+1)'(1));
  assign w_pat_next   = r_pat + STEP;
  assign w_mismatch   = r_pv[READ_LATENCY] && (i_m_readdata != r_pd[READ_LATENCY]);
  assign w_err_next   = (w_mismatch && (o_err_count != 16'hFFFF)) ? (o_err_count + 16'd1) : o_err_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_seed         <= '0;
      r_pat          <= '0;
      r_base         <= '0;
      r_count        <= '0;
      r_rem          <= '0;
      r_drain        <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_pass         <= 1'b0;
      o_cfg_err      <= 1'b0;
      o_err_count    <= '0;
      o_m_address    <= '0;
      o_m_byteenable <= '0;
      o_m_chipselect <= 1'b0;
      o_m_write      <= 1'b0;
      o_m_writedata  <= '0;
      for (int j = 0; j <= READ_LATENCY; j++) begin
        r_pv[j] <= 1'b0;
        r_pd[j] <= '0;
`ifdef MEM_TEST_ERRLOG_EN
        r_pa[j] <= '0;
`endif
      end
`ifdef MEM_TEST_ERRLOG_EN
      o_first_err_addr <= '0;
      o_first_err_data <= '0;
`endif
    end else begin
      o_done      <= 1'b0;
      o_err_count <= w_err_next;
      r_pv[0]     <= 1'b0;
      r_pd[0]     <= '0;
      for (int j = 1; j <= READ_LATENCY; j++) begin
        r_pv[j] <= r_pv[j-1];
        r_pd[j] <= r_pd[j-1];
`ifdef MEM_TEST_ERRLOG_EN
        r_pa[j] <= r_pa[j-1];
`endif
      end
`ifdef MEM_TEST_ERRLOG_EN
      r_pa[0] <= '0;
      // The counter saturates and never returns to zero, so zero means no earlier mismatch.
      if (w_mismatch && (o_err_count == 16'd0)) begin
        o_first_err_addr <= r_pa[READ_LATENCY];
        o_first_err_data <= i_m_readdata;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_seed      <= i_seed;
            r_base      <= i_base;
            r_count     <= i_count;
            o_err_count <= '0;
            o_pass      <= 1'b0;
            o_cfg_err   <= 1'b0;
`ifdef MEM_TEST_ERRLOG_EN
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
`endif
            if (w_bad_window) begin
              o_cfg_err <= 1'b1;
              o_done    <= 1'b1;
              r_state   <= S_DONE;
            end else if (i_count == '0) begin
              o_pass  <= 1'b1;
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_busy         <= 1'b1;
              o_m_chipselect <= 1'b1;
              o_m_byteenable <= 4'hF;
              o_m_write      <= 1'b1;
              o_m_address    <= i_base;
              o_m_writedata  <= i_seed;
              r_pat          <= i_seed;
              r_rem          <= i_count - ADDR_W'(1);
              r_state        <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (r_rem != '0) begin
            o_m_address   <= w_next_addr;
            o_m_writedata <= w_pat_next;
            r_pat         <= w_pat_next;
            r_rem         <= r_rem - ADDR_W'(1);
          end else begin
            o_m_write     <= 1'b0;
            o_m_writedata <= '0;
            o_m_address   <= r_base;
            r_pat         <= r_seed;
            r_pv[0]       <= 1'b1;
            r_pd[0]       <= r_seed;
`ifdef MEM_TEST_ERRLOG_EN
            r_pa[0]       <= r_base;
`endif
            r_rem         <= r_count - ADDR_W'(1);
            r_state       <= S_READ;
          end
        end
        S_READ: begin
          if (r_rem != '0) begin
            o_m_address <= w_next_addr;
            r_pat       <= w_pat_next;
            r_pv[0]     <= 1'b1;
            r_pd[0]     <= w_pat_next;
`ifdef MEM_TEST_ERRLOG_EN
            r_pa[0]     <= w_next_addr;
`endif
            r_rem       <= r_rem - ADDR_W'(1);
          end else begin
            o_m_chipselect <= 1'b0;
            o_m_byteenable <= '0;
            o_m_address    <= '0;
            if (READ_LATENCY == 0) begin
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_pass  <= (w_err_next == 16'd0) && !o_cfg_err;
              r_state <= S_DONE;
            end else begin
              r_drain <= 8'(READ_LATENCY);
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last compare lands on the same edge that raises done, hence w_err_next.
          if (r_drain == 8'd1) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_pass  <= (w_err_next == 16'd0) && !o_cfg_err;
            r_state <= S_DONE;
          end else begin
            r_drain <= r_drain - 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: ideal memory with optional single-bit fault, pattern/timing reference model.
module tb_onchip_mem_test_master;
  localparam int          DEPTH  = 51200;
  localparam int          ADDR_W = 16;
  localparam int          RL     = 1;
  localparam logic [31:0] STEP   = 32'h9E3779B9;

  typedef struct packed {
    logic [15:0] t;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] dat;
  } bus_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       seed = '0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W-1:0] count = '0;
  logic              busy, done, pass, cfg_err;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect, m_write;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata = '0;
`ifdef MEM_TEST_ERRLOG_EN
  logic [ADDR_W-1:0] first_err_addr;
  logic [31:0]       first_err_data;
`endif

  logic [31:0] mem [0:DEPTH-1];
  int          fault_addr = -1;
  int          checks = 0;
  int          errors = 0;
  bus_t        q_bus[$];
  bus_t        e_bus[$];
  int          obs_done_at, obs_done_n, obs_busy_n, obs_busy_last, obs_proto_bad;

  onchip_mem_test_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(RL), .STEP(STEP)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_seed(seed), .i_base(base), .i_count(count),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_cfg_err(cfg_err), .o_err_count(err_count),
`ifdef MEM_TEST_ERRLOG_EN
    .o_first_err_addr(first_err_addr), .o_first_err_data(first_err_data),
`endif
    .o_m_address(m_address), .o_m_byteenable(m_byteenable), .o_m_chipselect(m_chipselect),
    .o_m_write(m_write), .o_m_writedata(m_writedata), .i_m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Single-port memory, one-cycle read latency; a fault flips bit 0 of data read from fault_addr.
  always @(posedge clk) begin
    if (m_chipselect === 1'b1 && m_write === 1'b1) mem[m_address] <= m_writedata;
    if (m_chipselect === 1'b1 && m_write === 1'b0)
      m_readdata <= mem[m_address] ^ {31'd0, (int'(m_address) == fault_addr)};
  end

  task automatic model_bus(input logic [31:0] s, input int b, input int c);
    e_bus.delete();
    for (int i = 0; i < c; i++) e_bus.push_back(bus_t'({16'(i + 1), 1'b1, 16'((b + i) % DEPTH), s + 32'(i) * STEP}));
    for (int i = 0; i < c; i++) e_bus.push_back(bus_t'({16'(c + i + 1), 1'b0, 16'((b + i) % DEPTH), 32'h0}));
  endtask

  function automatic int model_errs(input int b, input int c);
    int n = 0;
    for (int i = 0; i < c; i++) if ((b + i) % DEPTH == fault_addr) n++;
    return n;
  endfunction

  function automatic int bus_diff();
    int n = (q_bus.size() == e_bus.size()) ? 0 : 1;
    foreach (e_bus[i]) if (i >= q_bus.size() || q_bus[i] !== e_bus[i]) n++;
    return n;
  endfunction

  // Pulses start for one cycle (t=0), then observes each following cycle t at the falling edge.
  task automatic run_window(input logic [31:0] s, input int b, input int c, input int poke_t);
    int limit = 2 * c + 30;
    q_bus.delete();
    obs_done_at = -1; obs_done_n = 0; obs_busy_n = 0; obs_busy_last = 0; obs_proto_bad = 0;
    @(negedge clk);
    seed = s; base = 16'(b); count = 16'(c); start = 1'b1;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      start = (t == poke_t);
      if (m_chipselect) q_bus.push_back(bus_t'({16'(t), m_write, m_address, m_write ? m_writedata : 32'h0}));
      if (m_write && !m_chipselect) obs_proto_bad++;
      if (m_chipselect && m_byteenable != 4'hF) obs_proto_bad++;
      if (busy) begin obs_busy_n++; obs_busy_last = t; end
      if (done) begin
        obs_done_n++;
        if (obs_done_at < 0) obs_done_at = t;
      end
      if (obs_done_at > 0 && t >= obs_done_at + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, cfg_err, err_count, m_address, m_byteenable, m_chipselect, m_write, m_writedata} !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b pass=%b cfg_err=%b err=%h cs=%b wr=%b addr=%h, all required 0",
                         busy, done, pass, cfg_err, err_count, m_chipselect, m_write, m_address);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, m_chipselect, m_write} !== 5'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b pass=%b cs=%b wr=%b, required 0", busy, done, pass, m_chipselect, m_write);
    end
  endtask

  task automatic test_basic();
    fault_addr = -1;
    model_bus(32'h0, 0, 4);
    run_window(32'h0, 0, 4, 0);
    checks++; if (bus_diff() != 0) begin errors++; $display("FAIL basic_bus: %0d bad of %0d observed, required 0 bad of %0d", bus_diff(), q_bus.size(), e_bus.size()); end
    checks++; if (obs_done_at != 10) begin errors++; $display("FAIL basic_done_cycle: got k+%0d, required k+10", obs_done_at); end
    checks++; if (obs_done_n != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, required 1", obs_done_n); end
    checks++; if ({pass, cfg_err, err_count} !== {1'b1, 1'b0, 16'd0}) begin errors++; $display("FAIL basic_result: pass=%b cfg_err=%b err=%0d, required 1 0 0", pass, cfg_err, err_count); end
    checks++; if ({mem[1], mem[2], mem[3]} !== {32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B}) begin errors++; $display("FAIL basic_mem: %h %h %h, required 9e3779b9 3c6ef372 daa66d2b", mem[1], mem[2], mem[3]); end
    checks++; if ({obs_busy_n, obs_busy_last} != {32'd9, 32'd9}) begin errors++; $display("FAIL basic_busy: %0d cycles ending k+%0d, required 9 ending k+9", obs_busy_n, obs_busy_last); end
    checks++; if (obs_proto_bad != 0) begin errors++; $display("FAIL basic_protocol: %0d violations, required 0", obs_proto_bad); end
  endtask

  task automatic test_wrap();
    fault_addr = -1;
    model_bus(32'h1234_5678, DEPTH - 2, 4);
    run_window(32'h1234_5678, DEPTH - 2, 4, 0);
    checks++; if (bus_diff() != 0) begin errors++; $display("FAIL wrap_bus: %0d bad entries, required 0", bus_diff()); end
    checks++;
    if (q_bus.size() < 8 || {q_bus[4].addr, q_bus[5].addr, q_bus[6].addr, q_bus[7].addr} !== {16'd51198, 16'd51199, 16'd0, 16'd1}) begin
      errors++; $display("FAIL wrap_read_addrs: %0d transfers seen, required reads at 51198 51199 0 1", q_bus.size());
    end
    checks++; if ({pass, err_count} !== {1'b1, 16'd0} || obs_done_at != 10) begin errors++; $display("FAIL wrap_result: pass=%b err=%0d done=k+%0d, required 1 0 k+10", pass, err_count, obs_done_at); end
  endtask

  task automatic test_fault();
    fault_addr = 5;
    run_window(32'h0, 0, 8, 0);
    checks++; if ({pass, err_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL fault_result: pass=%b err=%0d, required 0 1", pass, err_count); end
    checks++; if (obs_done_at != 18) begin errors++; $display("FAIL fault_done_cycle: got k+%0d, required k+18", obs_done_at); end
`ifdef MEM_TEST_ERRLOG_EN
    checks++; if (first_err_addr !== 16'd5) begin errors++; $display("FAIL fault_first_addr: got %0d, required 5", first_err_addr); end
    checks++; if (first_err_data !== ((32'd5 * STEP) ^ 32'd1)) begin errors++; $display("FAIL fault_first_data: got %h, required %h", first_err_data, (32'd5 * STEP) ^ 32'd1); end
`endif
    fault_addr = -1;
  endtask

  task automatic test_empty();
    run_window(32'hDEAD_BEEF, 10, 0, 0);
    checks++; if (obs_done_at != 1) begin errors++; $display("FAIL empty_done_cycle: got k+%0d, required k+1", obs_done_at); end
    checks++; if ({pass, cfg_err, err_count} !== {1'b1, 1'b0, 16'd0}) begin errors++; $display("FAIL empty_result: pass=%b cfg_err=%b err=%0d, required 1 0 0", pass, cfg_err, err_count); end
    checks++; if (q_bus.size() != 0 || obs_busy_n != 0) begin errors++; $display("FAIL empty_no_bus: %0d transfers, %0d busy cycles, required 0 0", q_bus.size(), obs_busy_n); end
  endtask

  task automatic test_illegal();
    int bases[2] = '{DEPTH, 0};
    int counts[2] = '{4, DEPTH + 1};
    for (int n = 0; n < 2; n++) begin
      run_window(32'h5, bases[n], counts[n], 0);
      checks++;
      if ({cfg_err, pass, err_count} !== {1'b1, 1'b0, 16'd0} || obs_done_at != 1) begin
        errors++; $display("FAIL illegal_%0d_result: cfg_err=%b pass=%b err=%0d done=k+%0d, required 1 0 0 k+1", n, cfg_err, pass, err_count, obs_done_at);
      end
      checks++;
      if (q_bus.size() != 0 || obs_busy_n != 0 || obs_proto_bad != 0) begin
        errors++; $display("FAIL illegal_%0d_bus: %0d transfers %0d busy cycles, required 0 0", n, q_bus.size(), obs_busy_n);
      end
    end
  endtask

  task automatic test_reset_busy();
    int done_seen = 0;
    fault_addr = -1;
    @(negedge clk);
    seed = 32'hA5A5_0001; base = 16'd100; count = 16'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_chipselect, m_write, busy} !== 3'b000) begin
      errors++; $display("FAIL midrun_reset: cs=%b wr=%b busy=%b, required 0 0 0", m_chipselect, m_write, busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (done || m_chipselect) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abandoned_run_activity: %0d cycles with done/cs, required 0", done_seen); end
    model_bus(32'h77, 300, 5);
    run_window(32'h77, 300, 5, 0);
    checks++;
    if (bus_diff() != 0 || obs_done_at != 12 || pass !== 1'b1) begin
      errors++; $display("FAIL rerun_after_reset: bad=%0d done=k+%0d pass=%b, required 0 k+12 1", bus_diff(), obs_done_at, pass);
    end
    model_bus(32'h99, 40, 6);
    run_window(32'h99, 40, 6, 8);
    checks++;
    if (bus_diff() != 0 || obs_done_at != 14 || obs_done_n != 1) begin
      errors++; $display("FAIL start_in_read: bad=%0d done=k+%0d pulses=%0d, required 0 k+14 1", bus_diff(), obs_done_at, obs_done_n);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] s = $urandom;
      int c = $urandom_range(1, 40);
      int b = (it % 2 == 1) ? DEPTH - int'($urandom_range(1, 20)) : int'($urandom_range(0, DEPTH - 1));
      int exp_err;
      fault_addr = ($urandom_range(0, 1) == 1) ? (b + int'($urandom_range(0, c - 1))) % DEPTH : -1;
      exp_err = model_errs(b, c);
      model_bus(s, b, c);
      run_window(s, b, c, 0);
      checks++;
      if (bus_diff() != 0 || obs_proto_bad != 0) begin
        errors++; $display("FAIL random_%0d_bus: base=%0d count=%0d bad=%0d proto=%0d, required 0 0", it, b, c, bus_diff(), obs_proto_bad);
      end
      checks++;
      if (obs_done_at != 2 * c + RL + 1 || {err_count, pass} !== {16'(exp_err), exp_err == 0}) begin
        errors++; $display("FAIL random_%0d_result: done=k+%0d err=%0d pass=%b, required k+%0d %0d %b", it, obs_done_at, err_count, pass, 2 * c + RL + 1, exp_err, exp_err == 0);
      end
    end
    fault_addr = -1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_empty();
    test_illegal();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
